// File: rtl/tappy_pkg.sv
// -----------------------------------------------------------------------------
// tappy_pkg
// Shared definitions for the PS/2 host transmitter (tappy_tx) and its
// companion receiver.
//   tappy_state_e   : frame state enum, ordering shared with the receiver
//   PS2_FRAME_BITS  : start + 8 data + parity + stop
//   PS2_DATA_BITS   : payload bits per frame
//   odd_parity()    : parity bit that makes the 9-bit {parity, data} odd
// The timeout feature of tappy_tx is selected with TAPPY_TX_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package tappy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_DATA,
      ST_PRTY,
      ST_STOP,
      ST_ACK,
      ST_WAIT
   } tappy_state_e;

   localparam int unsigned PS2_FRAME_BITS = 11;
   localparam int unsigned PS2_DATA_BITS  = 8;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/tappy_sync.sv
// -----------------------------------------------------------------------------
// tappy_sync
// Two-flop synchroniser for one PS/2 line plus a single-cycle falling-edge
// detector on the synchronised value. Flops reset to 1 (idle bus level) so
// no edge is reported when reset is released.
// Ports:
//   sysclk : system clock
//   rst_n  : asynchronous reset, active low
//   din    : raw PS/2 line
//   dout   : synchronised line
//   fall   : high for one cycle when dout goes 1 -> 0
// -----------------------------------------------------------------------------
module tappy_sync (
   input  logic sysclk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign dout = sync_q;
   assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/tappy_tx.sv
// -----------------------------------------------------------------------------
// tappy_tx
// PS/2 host-to-device transmitter. Sends one command byte to a keyboard over
// the open-drain clk/dat lines: inhibits the clock, issues request-to-send,
// then shifts start/data/parity/stop on device clock falling edges and checks
// the device acknowledge.
// Parameters:
//   INHIBIT_CYCLES : sysclk cycles the clock line is held low before RTS
//   TIMEOUT_CYCLES : sysclk cycles allowed between device clock falls
//                    (only with TAPPY_TX_TIMEOUT_EN defined)
// Ports:
//   sysclk, rst_n  : system clock, asynchronous active-low reset
//   clk, dat       : PS/2 lines (synchronised internally)
//   word, valid    : byte to send and request, accepted when valid && ready
//   ready          : high in IDLE
//   clk_oe, dat_oe : 1 = pull the line low, 0 = release
//   busy           : high in every state except IDLE
//   done, err      : one-cycle pulses in the terminating cycle
// Optional feature macro: TAPPY_TX_TIMEOUT_EN
// -----------------------------------------------------------------------------
module tappy_tx #(
   parameter int unsigned INHIBIT_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYCLES = 2000
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       clk,
   input  logic       dat,
   input  logic [7:0] word,
   input  logic       valid,
   output logic       ready,
   output logic       clk_oe,
   output logic       dat_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   import tappy_pkg::*;

   localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int unsigned BIT_W = $clog2(PS2_FRAME_BITS);
   localparam int unsigned CNT_W = (INH_W > BIT_W) ? INH_W : BIT_W;

   tappy_state_e     state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic             parity_q, parity_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             done_c, err_c;

   logic clk_sync, clk_fall;
   logic dat_sync, unused_dat_fall;

   tappy_sync u_clk_sync (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .din    (clk),
      .dout   (clk_sync),
      .fall   (clk_fall)
   );

   tappy_sync u_dat_sync (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .din    (dat),
      .dout   (dat_sync),
      .fall   (unused_dat_fall)
   );

`ifdef TAPPY_TX_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            timeout;

   // Held at zero through IDLE/INHIBIT, which also gives the clear on RTS entry.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_q == ST_IDLE || state_q == ST_INHIBIT || clk_fall) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES - 1)) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end

   // A fall arriving in the same cycle as expiry keeps the frame alive.
   assign timeout = (state_q != ST_IDLE) && (state_q != ST_INHIBIT) &&
                    !clk_fall && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
   localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      count_d  = count_q;
      clk_oe_d = clk_oe_q;
      dat_oe_d = dat_oe_q;
      done_c   = 1'b0;
      err_c    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (valid) begin
               shift_d  = word;
               parity_d = odd_parity(word);
               count_d  = '0;
               clk_oe_d = 1'b1;
               dat_oe_d = 1'b0;
               state_d  = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (count_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
               count_d  = '0;
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b1;          // start bit
               state_d  = ST_RTS;
            end else begin
               count_d  = count_q + CNT_W'(1);
            end
         end
         ST_RTS: begin
            if (clk_fall) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (clk_fall) begin
               dat_oe_d = ~shift_q[0];
               shift_d  = {1'b0, shift_q[7:1]};
               count_d  = count_q + CNT_W'(1);
               if (count_q == CNT_W'(PS2_DATA_BITS - 1)) begin
                  state_d = ST_PRTY;
               end
            end
         end
         ST_PRTY: begin
            if (clk_fall) begin
               dat_oe_d = ~parity_q;
               state_d  = ST_STOP;
            end
         end
         ST_STOP: begin
            if (clk_fall) begin
               dat_oe_d = 1'b0;          // stop bit
               state_d  = ST_ACK;
            end
         end
         ST_ACK: begin
            if (clk_fall) begin
               if (!dat_sync) begin
                  state_d = ST_WAIT;
               end else begin
                  err_c    = 1'b1;
                  dat_oe_d = 1'b0;
                  clk_oe_d = 1'b0;
                  state_d  = ST_IDLE;
               end
            end
         end
         ST_WAIT: begin
            if (clk_sync && dat_sync) begin
               done_c  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef TAPPY_TX_TIMEOUT_EN
      if (timeout && !done_c) begin
         err_c    = 1'b1;
         clk_oe_d = 1'b0;
         dat_oe_d = 1'b0;
         state_d  = ST_IDLE;
      end
`endif
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         parity_q <= 1'b0;
         count_q  <= '0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         count_q  <= count_d;
         clk_oe_q <= clk_oe_d;
         dat_oe_q <= dat_oe_d;
      end
   end

   assign ready  = (state_q == ST_IDLE);
   assign busy   = (state_q != ST_IDLE);
   assign clk_oe = clk_oe_q;
   assign dat_oe = dat_oe_q;
   assign done   = done_c;
   assign err    = err_c;

endmodule

// File: tb/tb_tappy_tx.sv
// -----------------------------------------------------------------------------
// tb_tappy_tx
// Self-checking bench for tappy_tx. A behavioural PS/2 device drives the
// open-drain bus (device clock period scaled down to tens of sysclk cycles),
// samples the host data on each rising edge and acks or nacks.
// Timeout expectations follow TAPPY_TX_TIMEOUT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tappy_tx;

   localparam int unsigned INH = 16;
   localparam int unsigned TO  = 300;

   logic       sysclk = 1'b0;
   logic       rst_n  = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       ps2_clk, ps2_dat;
   logic [7:0] word = 8'h00;
   logic       valid = 1'b0;
   logic       ready, clk_oe, dat_oe, busy, done, err;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   bit prev_term = 1'b0;

   assign ps2_clk = dev_clk & ~clk_oe;
   assign ps2_dat = dev_dat & ~dat_oe;

   always #5 sysclk = ~sysclk;

   tappy_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .clk    (ps2_clk),
      .dat    (ps2_dat),
      .word   (word),
      .valid  (valid),
      .ready  (ready),
      .clk_oe (clk_oe),
      .dat_oe (dat_oe),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected bus bits in transmission order: bit 0 = start ... bit 10 = stop.
   function automatic logic [10:0] model_frame(input logic [7:0] w);
      int unsigned ones = 0;
      logic [10:0] f;
      for (int unsigned i = 0; i < 8; i++) ones += w[i];
      f[0] = 1'b0;
      for (int unsigned i = 0; i < 8; i++) f[i+1] = w[i];
      f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
      f[10] = 1'b1;
      return f;
   endfunction

   // Pulse monitor: done/err exclusive, only while busy, busy drops right after.
   always @(negedge sysclk) begin
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
      if (done === 1'b1 || err === 1'b1) begin
         check("term_busy", busy, 1);
         check("term_exclusive", done & err, 0);
      end
      if (prev_term) check("busy_after_term", busy, 0);
      prev_term = (done === 1'b1 || err === 1'b1);
   end

   // Device side: optional lead-in, then nfalls clock periods. Samples the
   // host data just before each rising edge; pulls dat low for the ack clock.
   task automatic dev_run(input int nfalls, input bit ack_low, input int half,
                          output logic [10:0] bits);
      bits = '0;
      repeat (half) @(negedge sysclk);
      for (int i = 0; i < nfalls; i++) begin
         if (i == 11 && ack_low) dev_dat = 1'b0;
         dev_clk = 1'b0;
         repeat (half) @(negedge sysclk);
         if (i < 11) bits[i] = ps2_dat;
         dev_clk = 1'b1;
         if (i == 11) dev_dat = 1'b1;
         repeat (half) @(negedge sysclk);
      end
   endtask

   // Counts negedges with clk_oe high; returns at the first negedge it is low.
   task automatic measure_inhibit(output int len, output logic dat_drop);
      len = 0;
      for (int k = 0; k < 200 && clk_oe === 1'b1; k++) begin
         if (k == 2) valid = 1'b0;
         len++;
         @(negedge sysclk);
      end
      valid = 1'b0;
      dat_drop = dat_oe;
   endtask

   task automatic run_frame(input string name, input logic [7:0] w, input bit ack_low,
                            input int half, input bit armed);
      int d0, e0, inh_len;
      logic dat_drop;
      logic [10:0] bits;
      d0 = done_cnt;
      e0 = err_cnt;
      if (!armed) begin
         @(negedge sysclk);
         word  = w;
         valid = 1'b1;
      end
      @(negedge sysclk);
      word = ~w;                  // busy: must not disturb the frame
      measure_inhibit(inh_len, dat_drop);
      dev_run(12, ack_low, half, bits);
      for (int k = 0; k < 40 && ready !== 1'b1; k++) @(negedge sysclk);
      @(negedge sysclk);
      check({name, ".inhibit_len"}, inh_len, INH);
      check({name, ".dat_oe_at_drop"}, dat_drop, 1);
      check({name, ".bus_bits"}, bits, model_frame(w));
      check({name, ".done_count"}, done_cnt - d0, ack_low ? 1 : 0);
      check({name, ".err_count"}, err_cnt - e0, ack_low ? 0 : 1);
      check({name, ".ready"}, ready, 1);
      check({name, ".released"}, {clk_oe, dat_oe}, 0);
   endtask

   typedef struct {
      logic [7:0] w;
      bit         ack;
      logic       par;
   } vec_t;

   initial begin
      vec_t        tbl [7];
      logic [10:0] bits;
      int          d0, e0, first, inh_len, half;
      logic        dat_drop;
      logic [7:0]  rw;
      bit          rack;

      tbl[0] = '{8'hED, 1'b1, 1'b1};
      tbl[1] = '{8'hFF, 1'b1, 1'b1};
      tbl[2] = '{8'h00, 1'b1, 1'b1};
      tbl[3] = '{8'h01, 1'b1, 1'b0};
      tbl[4] = '{8'h5A, 1'b0, 1'b1};
      tbl[5] = '{8'h07, 1'b1, 1'b0};
      tbl[6] = '{8'hA5, 1'b1, 1'b1};

      // Reset state, with a request already pending.
      word  = tbl[0].w;
      valid = 1'b1;
      repeat (3) @(negedge sysclk);
      check("reset.ready", ready, 1);
      check("reset.busy", busy, 0);
      check("reset.clk_oe", clk_oe, 0);
      check("reset.dat_oe", dat_oe, 0);
      check("reset.done", done, 0);
      check("reset.err", err, 0);
      rst_n = 1'b1;

      // Table vectors; the first one is the request held through reset.
      for (int i = 0; i < 7; i++) begin
         run_frame($sformatf("vec%0d", i), tbl[i].w, tbl[i].ack, 20, i == 0);
         check($sformatf("vec%0d.parity_rule", i), model_frame(tbl[i].w) >> 9 & 11'h1, tbl[i].par);
      end

      // Randomised frames against the model.
      for (int i = 0; i < 20; i++) begin
         rw   = 8'($urandom);
         half = $urandom_range(6, 25);
         rack = ($urandom_range(0, 3) != 0);
         run_frame($sformatf("rnd%0d", i), rw, rack, half, 1'b0);
      end

      // Device stops clocking after data bit 3.
      @(negedge sysclk);
      word  = 8'h3C;
      valid = 1'b1;
      @(negedge sysclk);
      measure_inhibit(inh_len, dat_drop);
      dev_run(4, 1'b0, 10, bits);
      e0 = err_cnt;
      dev_clk = 1'b0;
      first = 0;
      for (int k = 1; k <= int'(TO) + 20; k++) begin
         @(negedge sysclk);
         if (err === 1'b1 && first == 0) first = k;
         if (k == 10) dev_clk = 1'b1;
      end
`ifdef TAPPY_TX_TIMEOUT_EN
      check("timeout.err_cycle", first, TO + 2);
      check("timeout.err_count", err_cnt - e0, 1);
      check("timeout.ready", ready, 1);
      check("timeout.released", {clk_oe, dat_oe}, 0);
`else
      check("stall.busy", busy, 1);
      check("stall.no_err", err_cnt - e0, 0);
      check("stall.err_seen", first, 0);
      #2 rst_n = 1'b0;
      @(negedge sysclk);
      rst_n = 1'b1;
      check("stall.ready_after_reset", ready, 1);
`endif

      // Reset in the middle of data bit 4 (0 in 8'hE5, so dat is pulled low).
      d0 = done_cnt;
      e0 = err_cnt;
      @(negedge sysclk);
      word  = 8'hE5;
      valid = 1'b1;
      @(negedge sysclk);
      measure_inhibit(inh_len, dat_drop);
      dev_run(6, 1'b0, 12, bits);
      check("midreset.pre_dat_oe", dat_oe, 1);
      check("midreset.pre_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midreset.lines_async", {clk_oe, dat_oe}, 0);
      check("midreset.ready", ready, 1);
      @(negedge sysclk);
      rst_n = 1'b1;
      repeat (2) @(negedge sysclk);
      check("midreset.no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
      run_frame("after_reset", 8'hE5, 1'b1, 15, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #10ms;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
